i2s_slave: RTL and testbench

I2S_SLAVE -- requirements
Module: i2s_slave

---
 rtl/i2s_pkg.sv | 12 +
 rtl/i2s_edge_sync.sv | 28 ++
 rtl/i2s_slave.sv | 175 +++++++++++++++++
 tb/tb_i2s_slave.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and FSM state type for the I2S slave.
package i2s_pkg;
  localparam int DATA_W_DEF   = 16;
  localparam int MIN_SLOT_DEF = 17;
  localparam int CNT_W        = 6;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2s_state_e;
endpackage

// File: rtl/i2s_edge_sync.sv
// Two-flop synchronizer plus history flop; emits single-clk rise/fall pulses.
module i2s_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_hist;

  // Resynchronise the asynchronous input and keep one sample of history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_hist;
  assign o_fall = ~r_sync & r_hist;
endmodule

// File: rtl/i2s_slave.sv
// I2S slave: receives a stereo word pair on SDin and transmits one on SDout,
// framed by the master's SCLK/LRCLK, with short-half-frame detection.
module i2s_slave
  import i2s_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MIN_SLOT = MIN_SLOT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              LRCLK,
  input  logic              SDin,
  output logic              SDout,
  input  logic [DATA_W-1:0] tx_lft,
  input  logic [DATA_W-1:0] tx_rht,
  output logic              tx_rdy,
  output logic [DATA_W-1:0] rx_lft,
  output logic [DATA_W-1:0] rx_rht,
  output logic              rx_vld,
  output logic              frame_err
);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_DW   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_SLOT);
  localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};

  logic w_sclk_rise, w_sclk_fall, w_lr_rise, w_lr_fall, w_lr_edge;
  logic r_sd_meta, r_sd_sync, r_sd_dly;
  i2s_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rx_sh, r_lft_hold, r_tx_sh, r_rht_hold;
  logic w_in_slot, w_err, w_load_l, w_load_r, w_hand_rx;

  i2s_edge_sync u_sclk_sync (
    .i_clk(clk), .i_rst(rst), .i_async(SCLK),
    .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  i2s_edge_sync u_lrclk_sync (
    .i_clk(clk), .i_rst(rst), .i_async(LRCLK),
    .o_rise(w_lr_rise), .o_fall(w_lr_fall)
  );

  // SDin gets the same depth as the SCLK history flop so samples line up with rise pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sd_meta <= 1'b0;
      r_sd_sync <= 1'b0;
      r_sd_dly  <= 1'b0;
    end else begin
      r_sd_meta <= SDin;
      r_sd_sync <= r_sd_meta;
      r_sd_dly  <= r_sd_sync;
    end
  end

  assign w_lr_edge = w_lr_rise | w_lr_fall;
  assign w_in_slot = (r_cnt >= CNT_ONE) && (r_cnt <= CNT_DW);
  assign w_err     = w_lr_edge && (r_state != ST_SYNC) && (r_cnt < CNT_MIN);

  always_comb begin
    w_state_nxt = r_state;
    w_load_l    = 1'b0;
    w_load_r    = 1'b0;
    w_hand_rx   = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_lr_fall) begin
          w_state_nxt = ST_LEFT;
          w_load_l    = 1'b1;
        end else begin
          w_state_nxt = ST_SYNC;
        end
      end
      ST_LEFT: begin
        if (w_err) begin
          w_state_nxt = ST_SYNC;
        end else if (w_lr_rise) begin
          w_state_nxt = ST_RIGHT;
          w_load_r    = 1'b1;
        end else begin
          w_state_nxt = ST_LEFT;
        end
      end
      ST_RIGHT: begin
        if (w_err) begin
          w_state_nxt = ST_SYNC;
        end else if (w_lr_fall) begin
          w_state_nxt = ST_LEFT;
          w_load_l    = 1'b1;
          w_hand_rx   = 1'b1;
        end else begin
          w_state_nxt = ST_RIGHT;
        end
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  // A rise coinciding with an LRCLK edge is the first rise of the new half-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SYNC;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      if (w_lr_edge) begin
        r_cnt <= w_sclk_rise ? CNT_ONE : CNT_ZERO;
      end else if (w_sclk_rise && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Receive path: shifter, left hold and the word-pair handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sh    <= WORD_ZERO;
      r_lft_hold <= WORD_ZERO;
      rx_lft     <= WORD_ZERO;
      rx_rht     <= WORD_ZERO;
      rx_vld     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_vld    <= w_hand_rx;
      frame_err <= w_err;
      if (w_lr_edge) begin
        r_rx_sh <= WORD_ZERO;
      end else if (w_sclk_rise && w_in_slot) begin
        r_rx_sh <= {r_rx_sh[DATA_W-2:0], r_sd_dly};
      end
      if (w_err) begin
        r_lft_hold <= WORD_ZERO;
      end else if (w_load_r) begin
        r_lft_hold <= r_rx_sh;
      end
      if (w_hand_rx) begin
        rx_lft <= r_lft_hold;
        rx_rht <= r_rx_sh;
      end
    end
  end

  // Transmit path: edges reload the shifter; falls 1..DATA_W clock it out MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_sh    <= WORD_ZERO;
      r_rht_hold <= WORD_ZERO;
      tx_rdy     <= 1'b0;
      SDout      <= 1'b0;
    end else begin
      tx_rdy <= w_load_l;
      if (w_load_l) begin
        r_tx_sh    <= tx_lft;
        r_rht_hold <= tx_rht;
      end else if (w_load_r) begin
        r_tx_sh <= r_rht_hold;
      end else if (w_sclk_fall && w_in_slot) begin
        r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
      end
      if (w_err || (w_state_nxt == ST_SYNC)) begin
        SDout <= 1'b0;
      end else if (w_sclk_fall) begin
        SDout <= (w_lr_edge || !w_in_slot) ? 1'b0 : r_tx_sh[DATA_W-1];
      end else begin
        SDout <= SDout;
      end
    end
  end
endmodule

// File: tb/tb_i2s_slave.sv
// Directed bench: a master BFM drives SCLK/LRCLK/SDin and captures SDout.
module tb_i2s_slave;
  localparam int HALF = 160;
  localparam int NLB  = 32;

  logic clk = 1'b0;
  logic rst, sclk, lrclk, sdin;
  logic [15:0] tx_lft, tx_rht;
  logic sdout, tx_rdy, rx_vld, frame_err;
  logic [15:0] rx_lft, rx_rht;

  int n_tests = 0;
  int n_fail  = 0;
  int n_err_clk = 0;
  int n_rdy = 0;
  logic [15:0] q_l[$];
  logic [15:0] q_r[$];

  i2s_slave #(.DATA_W(16), .MIN_SLOT(17)) dut (
    .clk(clk), .rst(rst), .SCLK(sclk), .LRCLK(lrclk), .SDin(sdin), .SDout(sdout),
    .tx_lft(tx_lft), .tx_rht(tx_rht), .tx_rdy(tx_rdy),
    .rx_lft(rx_lft), .rx_rht(rx_rht), .rx_vld(rx_vld), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rx_vld) begin
      q_l.push_back(rx_lft);
      q_r.push_back(rx_rht);
    end
    if (frame_err) n_err_clk++;
    if (tx_rdy) n_rdy++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_half(input logic lr, input logic [15:0] w, input int n,
                           output logic [15:0] cap);
    cap = 16'h0000;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      if (i == 0) lrclk = lr;
      sdin = (i >= 1 && i <= 16) ? w[16-i] : 1'b0;
      #HALF;
      sclk = 1'b1;
      if (i >= 1 && i <= 16) cap[16-i] = sdout;
      #HALF;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl,
                            output logic [15:0] cl, output logic [15:0] cr);
    send_half(1'b0, l, nl, cl);
    send_half(1'b1, r, 32, cr);
  endtask

  function automatic logic [15:0] lb_l(input int k);
    lb_l = 16'(k * 2049 + 1);
  endfunction

  function automatic logic [15:0] lb_r(input int k);
    lb_r = 16'(32768 - k * 771);
  endfunction

  initial begin
    logic [15:0] cl, cr;
    int n0, base, lb_mis;
    sclk = 1'b1; lrclk = 1'b1; sdin = 1'b0; rst = 1'b1;
    tx_lft = 16'hA5C3; tx_rht = 16'h0F0F;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_sdout",  32'(sdout), 32'd0);
    check_eq("rst_rx_vld", 32'(rx_vld), 32'd0);
    check_eq("rst_tx_rdy", 32'(tx_rdy), 32'd0);
    check_eq("rst_ferr",   32'(frame_err), 32'd0);
    check_eq("rst_rx_lft", 32'(rx_lft), 32'd0);
    check_eq("rst_rx_rht", 32'(rx_rht), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    #3;

    // reset released while LRCLK high: frame A only arms the FSM
    send_frame(16'h8001, 16'h7FFE, 32, cl, cr);
    check_eq("no_vld_before_pair", 32'(q_l.size()), 32'd0);
    n0 = n_rdy;
    send_frame(16'h8001, 16'h7FFE, 32, cl, cr);
    check_eq("vld_count_b", 32'(q_l.size()), 32'd1);
    check_eq("rx_lft_a", 32'(q_l[0]), 32'h8001);
    check_eq("rx_rht_a", 32'(q_r[0]), 32'h7FFE);
    check_eq("tx_cap_l", 32'(cl), 32'hA5C3);
    check_eq("tx_cap_r", 32'(cr), 32'h0F0F);
    send_frame(16'h1234, 16'hABCD, 32, cl, cr);
    check_eq("vld_count_c", 32'(q_l.size()), 32'd2);
    check_eq("rx_lft_b", 32'(q_l[1]), 32'h8001);
    check_eq("tx_rdy_per_fall", 32'(n_rdy - n0), 32'd2);

    // truncated left half
    send_frame(16'h5555, 16'hAAAA, 10, cl, cr);
    check_eq("ferr_once", 32'(n_err_clk), 32'd1);
    check_eq("vld_count_err", 32'(q_l.size()), 32'd3);
    check_eq("rx_lft_c", 32'(q_l[2]), 32'h1234);
    check_eq("rx_rht_c", 32'(q_r[2]), 32'hABCD);
    send_frame(16'h0000, 16'hFFFF, 32, cl, cr);
    check_eq("no_vld_err_frame", 32'(q_l.size()), 32'd3);
    send_frame(16'hFFFF, 16'h0000, 32, cl, cr);
    check_eq("vld_count_e", 32'(q_l.size()), 32'd4);
    check_eq("rx_lft_d", 32'(q_l[3]), 32'h0000);
    check_eq("rx_rht_d", 32'(q_r[3]), 32'hFFFF);

    // one-clk reset in the middle of the right half
    fork
      send_frame(16'h1357, 16'h2468, 32, cl, cr);
      begin
        #15240;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_rst_sdout",  32'(sdout), 32'd0);
        check_eq("mid_rst_rx_vld", 32'(rx_vld), 32'd0);
        check_eq("mid_rst_tx_rdy", 32'(tx_rdy), 32'd0);
        check_eq("mid_rst_ferr",   32'(frame_err), 32'd0);
        check_eq("mid_rst_rx_lft", 32'(rx_lft), 32'd0);
        check_eq("mid_rst_rx_rht", 32'(rx_rht), 32'd0);
        @(negedge clk) rst = 1'b0;
      end
    join
    check_eq("vld_count_x", 32'(q_l.size()), 32'd5);
    check_eq("rx_lft_e", 32'(q_l[4]), 32'hFFFF);
    check_eq("rx_rht_e", 32'(q_r[4]), 32'h0000);

    // ramp loopback; frame 0 starts from SYNC
    base = q_l.size();
    lb_mis = 0;
    for (int k = 0; k < NLB; k++) begin
      tx_lft = 16'(k * 4097 + 3);
      tx_rht = ~tx_lft;
      send_frame(lb_l(k), lb_r(k), 32, cl, cr);
      if (k >= 1 && (cl !== tx_lft || cr !== tx_rht)) lb_mis++;
    end
    send_half(1'b0, 16'h0000, 32, cl);
    repeat (10) @(negedge clk);
    check_eq("lb_vld_count", 32'(q_l.size() - base), 32'(NLB));
    for (int k = 0; k < NLB && (base + k) < q_l.size(); k++) begin
      if (q_l[base+k] !== lb_l(k) || q_r[base+k] !== lb_r(k)) lb_mis++;
    end
    check_eq("lb_mismatches", 32'(lb_mis), 32'd0);
    check_eq("ferr_total", 32'(n_err_clk), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
